// File: rtl/mem_rd_skew_ctrl_if.sv
// mem_rd_skew_ctrl_if
//   Bundles the command and read-sweep signals of the skewed read controller.
//   master : the control sequencer side. It drives start, base_addr, len and
//            stall, and observes the sweep outputs.
//   slave  : the controller side. It consumes the commands and drives rd_en,
//            rd_addr, wr_active, busy and done.
//   Ports carried:
//     start      run request
//     base_addr  first address of every bank
//     len        vectors per bank
//     stall      hold request from the memory arbiter
//     rd_en      per-bank read enable, bit i = bank i
//     rd_addr    per-bank address, lane i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//     wr_active  output-write window for the array results
//     busy       run in progress
//     done       one-cycle pulse after the last step
interface mem_rd_skew_ctrl_if #(
  parameter int WIDTH_HEIGHT = 16,
  parameter int ADDR_WIDTH   = 8,
  parameter int LEN_WIDTH    = 8
);
  logic                               start;
  logic [ADDR_WIDTH-1:0]              base_addr;
  logic [LEN_WIDTH-1:0]               len;
  logic                               stall;
  logic [WIDTH_HEIGHT-1:0]            rd_en;
  logic [WIDTH_HEIGHT*ADDR_WIDTH-1:0] rd_addr;
  logic                               wr_active;
  logic                               busy;
  logic                               done;

  modport master (
    output start, base_addr, len, stall,
    input  rd_en, rd_addr, wr_active, busy, done
  );

  modport slave (
    input  start, base_addr, len, stall,
    output rd_en, rd_addr, wr_active, busy, done
  );
endinterface

// File: rtl/mem_rd_skew_ctrl.sv
// mem_rd_skew_ctrl
//   Read controller for the systolic-array input buffers. A start command
//   launches a diagonally skewed read sweep over WIDTH_HEIGHT banks: bank i
//   lags bank i-1 by one step. Each bank reads len consecutive addresses
//   from base_addr. A write-enable window (wr_active) for the array results
//   opens at step WR_DELAY and stays open for len steps. A stall from the
//   memory arbiter freezes progress and blanks the outputs for that cycle.
//   Ports:
//     clk    rising-edge clock
//     reset  asynchronous active-high reset
//     bus    mem_rd_skew_ctrl_if.slave (commands in, sweep outputs out)
//   All outputs are registered.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | waiting for start with non-zero len; outputs zero
//   RUN   | issuing steps 0..WR_DELAY+len-1, cnt = next step to issue
module mem_rd_skew_ctrl #(
  parameter int WIDTH_HEIGHT = 16,
  parameter int ADDR_WIDTH   = 8,
  parameter int LEN_WIDTH    = 8,
  parameter int WR_DELAY     = WIDTH_HEIGHT
) (
  input logic               clk,
  input logic               reset,
  mem_rd_skew_ctrl_if.slave bus
);

  // The step counter must reach WR_DELAY + (2^LEN_WIDTH - 1) without wrapping.
  localparam int CNT_W = $clog2(WR_DELAY + (1 << LEN_WIDTH));

  // The last bank starts at step WIDTH_HEIGHT-1. A smaller WR_DELAY would
  // end the run before that bank had read all of its vectors.
  generate
    if (WR_DELAY < WIDTH_HEIGHT - 1) begin : g_bad_wr_delay
      $error("mem_rd_skew_ctrl: WR_DELAY must be >= WIDTH_HEIGHT-1");
    end
  endgenerate

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic [CNT_W-1:0]      cnt_q,  cnt_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [LEN_WIDTH-1:0]  len_q,  len_d;

  logic                               busy_q,    busy_d;
  logic                               done_q,    done_d;
  logic [WIDTH_HEIGHT-1:0]            rd_en_q,   rd_en_d;
  logic [WIDTH_HEIGHT*ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic                               wr_q,      wr_d;

  // Step selection: the step that would be issued at the next edge, together
  // with the base/len it uses. In IDLE this is step 0 of the incoming command,
  // so the first step can be loaded on the same edge that accepts start.
  logic [CNT_W-1:0]      sel_step;
  logic [ADDR_WIDTH-1:0] sel_base;
  logic [LEN_WIDTH-1:0]  sel_len;

  // Decoded issue values for sel_step.
  logic [WIDTH_HEIGHT-1:0]            dec_rd_en;
  logic [WIDTH_HEIGHT*ADDR_WIDTH-1:0] dec_rd_addr;
  logic                               dec_wr;

  logic             issue;
  logic [CNT_W-1:0] run_len;

  assign run_len = CNT_W'(WR_DELAY) + CNT_W'(len_q);

  always_comb begin
    sel_step = cnt_q;
    sel_base = base_q;
    sel_len  = len_q;
    if (state_q == S_IDLE) begin
      sel_step = '0;
      sel_base = bus.base_addr;
      sel_len  = bus.len;
    end
  end

  // Bank i is active on steps i .. i+len-1 and reads base + (step - i).
  // The lower bound is tested first, so the subtraction never underflows.
  // The address add wraps at 2^ADDR_WIDTH.
  always_comb begin
    dec_rd_en   = '0;
    dec_rd_addr = '0;
    dec_wr      = 1'b0;
    for (int i = 0; i < WIDTH_HEIGHT; i++) begin
      if ((sel_step >= CNT_W'(i)) &&
          ((sel_step - CNT_W'(i)) < CNT_W'(sel_len))) begin
        dec_rd_en[i] = 1'b1;
        dec_rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH] =
          sel_base + ADDR_WIDTH'(sel_step - CNT_W'(i));
      end
    end
    if ((sel_step >= CNT_W'(WR_DELAY)) &&
        ((sel_step - CNT_W'(WR_DELAY)) < CNT_W'(sel_len))) begin
      dec_wr = 1'b1;
    end
  end

  // Next state and registered-output values.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    base_d    = base_q;
    len_d     = len_q;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    issue     = 1'b0;
    rd_en_d   = '0;
    rd_addr_d = '0;
    wr_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        // A zero-length command would produce no reads at all, so it is ignored.
        if (bus.start && (bus.len != '0)) begin
          state_d = S_RUN;
          base_d  = bus.base_addr;
          len_d   = bus.len;
          cnt_d   = CNT_W'(1);
          busy_d  = 1'b1;
          issue   = 1'b1;
        end
      end

      S_RUN: begin
        busy_d = 1'b1;
        // While stalled, cnt holds. The step that was due is issued on the
        // first edge without a stall.
        if (!bus.stall) begin
          if (cnt_q == run_len) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
            issue = 1'b1;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    if (issue) begin
      rd_en_d   = dec_rd_en;
      rd_addr_d = dec_rd_addr;
      wr_d      = dec_wr;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      base_q    <= '0;
      len_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rd_en_q   <= '0;
      rd_addr_q <= '0;
      wr_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      base_q    <= base_d;
      len_q     <= len_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      rd_en_q   <= rd_en_d;
      rd_addr_q <= rd_addr_d;
      wr_q      <= wr_d;
    end
  end

  assign bus.rd_en     = rd_en_q;
  assign bus.rd_addr   = rd_addr_q;
  assign bus.wr_active = wr_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_mem_rd_skew_ctrl.sv
// Testbench for mem_rd_skew_ctrl: a reference-model scoreboard on a W=4
// instance, directed checks for the listed scenarios, and a default-parameter
// instance.
module tb_mem_rd_skew_ctrl;
  localparam int W   = 4;
  localparam int AW  = 8;
  localparam int LW  = 8;
  localparam int WRD = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_rd_skew_ctrl_if #(.WIDTH_HEIGHT(W), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) bus ();
  mem_rd_skew_ctrl #(.WIDTH_HEIGHT(W), .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .WR_DELAY(WRD)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  mem_rd_skew_ctrl_if bus16 ();
  mem_rd_skew_ctrl dut16 (.clk(clk), .reset(reset), .bus(bus16));

  typedef struct packed {
    logic [W-1:0]    rd_en;
    logic [W*AW-1:0] rd_addr;
    logic            wr;
    logic            busy;
    logic            done;
  } obs_t;

  obs_t expq[$];
  int   pending[$];
  int   m_base;
  int   m_len;
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [3:0] basic_en [8]  = '{4'h1, 4'h3, 4'h7, 4'hE, 4'hC, 4'h8, 4'h0, 4'h0};
  logic [3:0] stall_en [10] = '{4'h1, 4'h3, 4'h7, 4'h0, 4'h0, 4'hE, 4'hC, 4'h8, 4'h0, 4'h0};

  // Issue values of step t, written directly from the sweep definition.
  function automatic obs_t step_vals(int t, int b, int l);
    obs_t o;
    o = '0;
    for (int i = 0; i < W; i++) begin
      if (t >= i && t < i + l) begin
        o.rd_en[i] = 1'b1;
        o.rd_addr[i*AW +: AW] = AW'((b + t - i) & ((1 << AW) - 1));
      end
    end
    o.wr   = (t >= WRD && t < WRD + l);
    o.busy = 1'b1;
    return o;
  endfunction

  // Reference model. An accepted run becomes a queue of remaining step numbers
  // with -1 marking the done cycle. A stalled edge consumes nothing.
  always @(posedge clk) begin
    obs_t e;
    int   t;
    e = '0;
    if (reset) begin
      pending.delete();
    end else if (pending.size() == 0) begin
      if (bus.start && bus.len != 0) begin
        m_base = int'(bus.base_addr);
        m_len  = int'(bus.len);
        e = step_vals(0, m_base, m_len);
        for (int s = 1; s < WRD + m_len; s++) pending.push_back(s);
        pending.push_back(-1);
      end
    end else if (bus.stall) begin
      e.busy = 1'b1;
    end else begin
      t = pending.pop_front();
      if (t < 0) e.done = 1'b1;
      else e = step_vals(t, m_base, m_len);
    end
    expq.push_back(e);
  end

  // Monitor: compares the DUT outputs with the oldest expected record.
  always @(negedge clk) begin
    obs_t a;
    obs_t e;
    if (expq.size() != 0) begin
      e = expq.pop_front();
      a.rd_en   = bus.rd_en;
      a.rd_addr = bus.rd_addr;
      a.wr      = bus.wr_active;
      a.busy    = bus.busy;
      a.done    = bus.done;
      n_cmp++;
      if (a !== e) begin
        n_bad++;
        $display("FAIL scoreboard @%0t act en=%b addr=%h wr=%b busy=%b done=%b req en=%b addr=%h wr=%b busy=%b done=%b",
                 $time, a.rd_en, a.rd_addr, a.wr, a.busy, a.done,
                 e.rd_en, e.rd_addr, e.wr, e.busy, e.done);
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s @%0t act=%0h req=%0h", nm, $time, act, req);
    end
  endtask

  initial begin
    logic [15:0] m16;
    logic [3:0]  ex_en;
    logic        ex_wr;

    reset = 1'b1;
    bus.start = 1'b0; bus.base_addr = '0; bus.len = '0; bus.stall = 1'b0;
    bus16.start = 1'b0; bus16.base_addr = '0; bus16.len = '0; bus16.stall = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_state", {bus.rd_en, bus.rd_addr, bus.wr_active, bus.busy, bus.done}, 64'h0);
    reset = 1'b0;

    // Default parameters: W=16, WR_DELAY=16, base 0, len 16, T=32.
    @(negedge clk);
    bus16.start = 1'b1; bus16.base_addr = 8'h00; bus16.len = 8'd16;
    @(negedge clk);
    bus16.start = 1'b0;
    for (int t = 0; t < 32; t++) begin
      if (t < 16) m16 = 16'((32'h1 << (t + 1)) - 1);
      else        m16 = 16'(32'hFFFF << (t - 15));
      chk("dflt_step", {bus16.busy, bus16.wr_active, bus16.rd_en},
          {1'b1, 1'(t >= 16), m16});
      @(negedge clk);
    end
    chk("dflt_done", {bus16.busy, bus16.done, bus16.rd_en}, {1'b0, 1'b1, 16'h0});

    // Basic run: base 0x10, len 3.
    @(negedge clk);
    bus.start = 1'b1; bus.base_addr = 8'h10; bus.len = 8'd3;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
      ex_wr = (k >= 4 && k < 7);
      chk("basic_step", {bus.busy, bus.done, bus.wr_active, bus.rd_en},
          {1'(k < 7), 1'(k == 7), ex_wr, basic_en[k]});
      if (k == 2) chk("basic_lanes_step2", bus.rd_addr[23:0], 24'h101112);
    end

    // Same run, stalled on the two edges that would issue step 3.
    @(negedge clk);
    bus.start = 1'b1; bus.base_addr = 8'h10; bus.len = 8'd3;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
      bus.stall = (k == 2 || k == 3);
      ex_wr = (k >= 6 && k < 9);
      chk("stall_step", {bus.busy, bus.done, bus.wr_active, bus.rd_en},
          {1'(k < 9), 1'(k == 9), ex_wr, stall_en[k]});
      if (k == 5) chk("stall_lanes_step3", bus.rd_addr[31:8], 24'h101112);
    end
    bus.stall = 1'b0;

    // Address wrap, an ignored mid-run start, and a start in the done cycle.
    @(negedge clk);
    bus.start = 1'b1; bus.base_addr = 8'hFE; bus.len = 8'd4;
    for (int k = 0; k <= 8; k++) begin
      @(negedge clk);
      bus.start = (k == 3);
      if (k == 3) begin bus.base_addr = 8'h55; bus.len = 8'd9; end
      if (k < 4) chk("wrap_lane0", bus.rd_addr[7:0], 8'(8'hFE + k));
      chk("wrap_busy_done", {bus.busy, bus.done}, (k < 8) ? 2'b10 : 2'b01);
      if (k == 8) begin bus.start = 1'b1; bus.base_addr = 8'h20; bus.len = 8'd2; end
    end
    @(negedge clk);
    bus.start = 1'b0;
    chk("b2b_step0", {bus.busy, bus.rd_en, bus.rd_addr[7:0]}, {1'b1, 4'b0001, 8'h20});
    repeat (8) @(negedge clk);

    // A start with len=0 is ignored.
    bus.start = 1'b1; bus.base_addr = 8'h33; bus.len = 8'd0;
    @(negedge clk);
    bus.start = 1'b0;
    chk("len0_a", {bus.busy, bus.done}, 2'b00);
    @(negedge clk);
    chk("len0_b", {bus.busy, bus.done}, 2'b00);

    // Asynchronous reset during step 4.
    bus.start = 1'b1; bus.base_addr = 8'h30; bus.len = 8'd5;
    for (int k = 0; k <= 4; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    #1 reset = 1'b1;
    #1 chk("async_reset", {bus.rd_en, bus.rd_addr, bus.wr_active, bus.busy, bus.done}, 64'h0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("post_reset_no_done", {bus.busy, bus.done}, 2'b00);
    bus.start = 1'b1; bus.base_addr = 8'h40; bus.len = 8'd1;
    @(negedge clk);
    bus.start = 1'b0;
    ex_en = 4'b0001;
    chk("post_reset_step0", {bus.busy, bus.rd_en, bus.rd_addr[7:0]}, {1'b1, ex_en, 8'h40});

    // Randomised traffic, checked by the scoreboard.
    for (int n = 0; n < 1500; n++) begin
      @(negedge clk);
      bus.start     = ($urandom_range(0, 3) == 0);
      bus.base_addr = 8'($urandom);
      if ($urandom_range(0, 7) == 0)       bus.len = 8'd0;
      else if ($urandom_range(0, 15) == 0) bus.len = 8'($urandom_range(7, 40));
      else                                 bus.len = 8'($urandom_range(1, 6));
      bus.stall     = ($urandom_range(0, 3) == 0);
    end
    bus.start = 1'b0; bus.stall = 1'b0;
    repeat (60) @(negedge clk);
    chk("run_drained", {31'h0, bus.busy}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
